// File: rtl/onehot_encoder_8to3.sv
// onehot_encoder_8to3
//   Sequential 8-to-3 encoder. It captures the line vector n on start and
//   scans the captured copy MSB-first, one bit per clock. It then presents the
//   index of the highest set line on {x,y,z}, together with one-hot, all-zero
//   and multi-hot status flags. Results are held in DONE until ack.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   n      in   [7:0] line vector (n[7] -> code 7)
//   start  in   capture request, honoured in IDLE only
//   ack    in   result acknowledge, honoured in DONE only
//   x,y,z  out  code bits 2,1,0 of the highest set line (000 if none)
//   busy   out  high while scanning
//   done   out  high while results are presented
//   onehot out  exactly one captured bit was set
//   none   out  no captured bit was set
//   multi  out  two or more captured bits were set
module onehot_encoder_8to3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] n,
  input  logic       start,
  input  logic       ack,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       onehot,
  output logic       none,
  output logic       multi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;

  logic [7:0]  cap;
  logic [2:0]  idx;
  logic        hit;
  logic [1:0]  ones;
  logic [2:0]  code;

  logic        bit_set;
  logic        hit_nx;
  logic [1:0]  ones_nx;
  logic [2:0]  code_nx;

  // Set-bit counter that sticks at 2: only 0 / 1 / "two or more" matter.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd2 : v + 2'd1;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)      state_nx = SCAN;
      SCAN:    if (idx == 3'd0) state_nx = DONE;
      DONE:    if (ack)        state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // One scan step on the current bit. The DONE outputs are loaded from these
  // next values so that bit 0 is included in the result.
  always_comb begin
    bit_set = cap[idx];
    hit_nx  = hit | bit_set;
    code_nx = (bit_set && !hit) ? idx : code;
    ones_nx = bit_set ? sat_inc(ones) : ones;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap    <= 8'd0;
      idx    <= 3'd7;
      hit    <= 1'b0;
      ones   <= 2'd0;
      code   <= 3'd0;
      x      <= 1'b0;
      y      <= 1'b0;
      z      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      onehot <= 1'b0;
      none   <= 1'b0;
      multi  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap  <= n;
            idx  <= 3'd7;
            hit  <= 1'b0;
            ones <= 2'd0;
            code <= 3'd0;
            busy <= 1'b1;
          end
        end
        SCAN: begin
          hit  <= hit_nx;
          code <= code_nx;
          ones <= ones_nx;
          if (idx != 3'd0) begin
            idx <= idx - 3'd1;
          end else begin
            busy      <= 1'b0;
            done      <= 1'b1;
            {x, y, z} <= hit_nx ? code_nx : 3'd0;
            onehot    <= (ones_nx == 2'd1);
            none      <= (ones_nx == 2'd0);
            multi     <= (ones_nx == 2'd2);
          end
        end
        DONE: begin
          // Code and flags are deliberately left holding after ack.
          if (ack) done <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_encoder_8to3.sv
module tb_onehot_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] n;
  logic       start;
  logic       ack;
  logic       x, y, z, busy, done, onehot, none, multi;

  int checks   = 0;
  int failures = 0;

  logic [5:0] res;
  assign res = {x, y, z, onehot, none, multi};

  onehot_encoder_8to3 dut (
    .clk(clk), .rst(rst), .n(n), .start(start), .ack(ack),
    .x(x), .y(y), .z(z), .busy(busy), .done(done),
    .onehot(onehot), .none(none), .multi(multi)
  );

  always #5 clk = ~clk;

  // Reference: index of the highest set line plus population-based flags.
  function automatic logic [5:0] model(input logic [7:0] v);
    logic [2:0] c;
    int         cnt;
    c   = 3'd0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        c = i[2:0];
        cnt++;
      end
    end
    return {c, cnt == 1, cnt == 0, cnt > 1};
  endfunction

  // Pulse start with v and count cycles until done (bounded).
  task automatic capture(input logic [7:0] v, output int lat);
    @(negedge clk);
    n = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; n = 8'h00; start = 1'b0; ack = 1'b0;
    #3;
    checks++;
    if ({res, busy, done} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", {res, busy, done}, 8'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_onehot_sweep();
    int lat;
    for (int k = 0; k < 8; k++) begin
      capture(8'(1 << k), lat);
      checks++;
      if (lat !== 8) begin
        failures++;
        $display("FAIL sweep_latency k=%0d got=%0d want=8", k, lat);
      end
      checks++;
      if (res !== model(8'(1 << k)) || busy !== 1'b0) begin
        failures++;
        $display("FAIL sweep_result k=%0d got=%b busy=%b want=%b busy=0", k, res, busy, model(8'(1 << k)));
      end
      do_ack();
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL sweep_ack k=%0d done=%b want=0", k, done);
      end
    end
  endtask

  task automatic test_zero_and_multi();
    int lat;
    logic [7:0] vecs [3];
    logic [5:0] want [3];
    vecs[0] = 8'h00;       want[0] = {3'b000, 3'b010};
    vecs[1] = 8'b0010_1001; want[1] = {3'b101, 3'b001};
    vecs[2] = 8'hFF;       want[2] = {3'b111, 3'b001};
    for (int i = 0; i < 3; i++) begin
      capture(vecs[i], lat);
      checks++;
      if (lat !== 8 || res !== want[i]) begin
        failures++;
        $display("FAIL fixed_vec n=%h got=%b lat=%0d want=%b lat=8", vecs[i], res, lat, want[i]);
      end
      do_ack();
    end
  endtask

  task automatic test_reset_mid();
    // Previous result is non-zero, so the reset clear is visible.
    @(negedge clk);
    n = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({res, busy, done} !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b want=%b", {res, busy, done}, 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_no_done cyc=%0d done=%b busy=%b want=0/0", i, done, busy);
      end
    end
    begin
      int lat;
      capture(8'h10, lat);
      checks++;
      if (lat !== 8 || res !== model(8'h10)) begin
        failures++;
        $display("FAIL reset_mid_restart got=%b lat=%0d want=%b lat=8", res, lat, model(8'h10));
      end
      do_ack();
    end
  endtask

  task automatic test_capture_isolation();
    logic [5:0] want;
    int pulses;
    logic prev;
    want = model(8'h04);
    @(negedge clk);
    n = 8'h04; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) begin n = 8'h80; start = 1'b1; end
      if (i == 3) start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL iso_scan cyc=%0d busy=%b done=%b want=1/0", i, busy, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || res !== want) begin
      failures++;
      $display("FAIL iso_result done=%b busy=%b got=%b want=1/0/%b", done, busy, res, want);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || res !== want) begin
        failures++;
        $display("FAIL hold cyc=%0d done=%b busy=%b got=%b want=1/0/%b", i, done, busy, res, want);
      end
    end
    do_ack();
    pulses = 0;
    prev = done;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done && !prev) pulses++;
      prev = done;
    end
    checks++;
    if (pulses !== 0 || busy !== 1'b0 || res !== want) begin
      failures++;
      $display("FAIL iso_not_queued extra_done=%0d busy=%b got=%b want=0/0/%b", pulses, busy, res, want);
    end
  endtask

  task automatic test_start_ack_together();
    int lat;
    capture(8'h40, lat);
    @(negedge clk);
    n = 8'h01; start = 1'b1; ack = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_ack_idle done=%b busy=%b want=0/0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res !== model(8'h40)) begin
      failures++;
      $display("FAIL start_ack_no_capture busy=%b got=%b want=0/%b", busy, res, model(8'h40));
    end
    capture(8'h02, lat);
    checks++;
    if (lat !== 8 || res !== {3'b001, 3'b100}) begin
      failures++;
      $display("FAIL start_ack_next got=%b lat=%0d want=001100 lat=8", res, lat);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int lat;
    capture(8'h08, lat);
    // ack in first DONE cycle, start immediately on the following edge
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; n = 8'h60; start = 1'b1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ack done=%b want=0", done);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept busy=%b want=1", busy);
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8 || res !== model(8'h60)) begin
      failures++;
      $display("FAIL b2b_result got=%b lat=%0d want=%b lat=8", res, lat, model(8'h60));
    end
    do_ack();
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] v;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 8'(1 << $urandom_range(0, 7));
        1:       v = 8'h00;
        default: v = 8'($urandom);
      endcase
      capture(v, lat);
      checks++;
      if (lat !== 8 || res !== model(v) || busy !== 1'b0) begin
        failures++;
        $display("FAIL random n=%h got=%b lat=%0d busy=%b want=%b lat=8 busy=0", v, res, lat, busy, model(v));
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_onehot_sweep();
    test_reset_mid();
    test_zero_and_multi();
    test_capture_isolation();
    test_start_ack_together();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
